// File: rtl/serial_xfer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_xfer_ctrl_pkg
// Shared definitions for the serial transfer controller:
//   - FSM state encoding (2'd3 is unused and recovers to IDLE in the FSM)
//   - eff_len(): effective transfer length rule, where a request of 0 or of
//     more than the chain width means a full-width transfer
// ----------------------------------------------------------------------------
package serial_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } xfer_state_e;

  // Map a requested bit count onto the count actually shifted.
  function automatic int unsigned eff_len(input int unsigned len,
                                          input int unsigned width);
    int unsigned n;
    if ((len == 32'd0) || (len > width)) begin
      n = width;
    end else begin
      n = len;
    end
    return n;
  endfunction

endpackage

// File: rtl/serial_xfer_ctrl_shift_chain.sv
// ----------------------------------------------------------------------------
// shift_chain
// WIDTH-bit chain of D flip-flops with parallel load and left shift.
// Load has priority over shift; with neither enable the chain holds.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low clear
//   load_en    load load_data into the chain
//   shift_en   shift left by one, ser_in enters at bit 0
//   load_data  parallel load value
//   ser_in     serial input bit
//   chain_q    current chain contents (bit WIDTH-1 is the serial output end)
// ----------------------------------------------------------------------------
module shift_chain #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] chain_q
);

  logic [WIDTH-1:0] chain_r;
  logic [WIDTH-1:0] chain_nxt_s;

  // Next-value select for every flip-flop in the chain.
  always_comb begin
    chain_nxt_s = chain_r;
    if (load_en) begin
      chain_nxt_s = load_data;
    end else if (shift_en) begin
      chain_nxt_s = {chain_r[WIDTH-2:0], ser_in};
    end else begin
      chain_nxt_s = chain_r;
    end
  end

  // The flip-flop chain itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {WIDTH{1'b0}};
    end else begin
      chain_r <= chain_nxt_s;
    end
  end

  assign chain_q = chain_r;

endmodule

// File: rtl/serial_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// serial_xfer_ctrl
// Full-duplex serial shifter controller. On Start it loads DataIn so that
// DataIn[N-1] sits at the chain MSB, shifts N bits out MSB-first on Dout while
// capturing Din into the chain, then presents the received word on RxData with
// a one-cycle Done pulse.
// Ports:
//   Clkin   clock, rising edge
//   Resetn  asynchronous active-low reset (aborts any transfer, clears RxData)
//   Start   transfer request, sampled only in IDLE
//   Len     bit count N (0 or > WIDTH means WIDTH)
//   DataIn  parallel word to send, bits [N-1:0] used
//   Din     serial receive bit
//   Dout    serial transmit bit (0 outside SHIFT)
//   Busy    high while shifting
//   Done    one-cycle completion pulse
//   RxData  received word, first Din bit in RxData[N-1], upper bits 0
// ----------------------------------------------------------------------------
module serial_xfer_ctrl
  import serial_xfer_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             Clkin,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [LEN_W-1:0] Len,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Din,
  output logic             Dout,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] RxData
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1'b1);

  xfer_state_e      state_r;
  xfer_state_e      state_nxt_s;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] n_r;
  logic [WIDTH-1:0] rx_r;
  logic             busy_r;
  logic             done_r;

  logic             load_en_s;
  logic             shift_en_s;
  logic             capture_s;
  int unsigned      n_eff_s;
  logic [WIDTH-1:0] load_val_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] chain_q_s;
  logic [WIDTH-1:0] rx_nxt_s;

  shift_chain #(
    .WIDTH (WIDTH)
  ) u_chain (
    .clk       (Clkin),
    .rst_n     (Resetn),
    .load_en   (load_en_s),
    .shift_en  (shift_en_s),
    .load_data (load_val_s),
    .ser_in    (Din),
    .chain_q   (chain_q_s)
  );

  // Effective length and MSB-aligned load word, taken from the live inputs
  // (only used on the accepting edge).
  always_comb begin
    n_eff_s    = eff_len(32'(Len), WIDTH);
    load_val_s = DataIn << (WIDTH - n_eff_s);
  end

  // Receive mask keeps bits [N-1:0] of the latched length.
  always_comb begin
    mask_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(n_r)) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
    // The last Din bit is not in the chain yet on the capturing edge.
    rx_nxt_s = {chain_q_s[WIDTH-2:0], Din} & mask_s;
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_en_s   = 1'b0;
    shift_en_s  = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          load_en_s   = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_en_s = 1'b1;
        if (cnt_r == CNT_ONE) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bit counter and latched transfer length.
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      cnt_r <= {LEN_W{1'b0}};
      n_r   <= {LEN_W{1'b0}};
    end else if (load_en_s) begin
      cnt_r <= LEN_W'(n_eff_s);
      n_r   <= LEN_W'(n_eff_s);
    end else if (shift_en_s) begin
      cnt_r <= cnt_r - CNT_ONE;
      n_r   <= n_r;
    end else begin
      cnt_r <= cnt_r;
      n_r   <= n_r;
    end
  end

  // Received-word register, updated only on the final shift edge.
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      rx_r <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      rx_r <= rx_nxt_s;
    end else begin
      rx_r <= rx_r;
    end
  end

  // Registered status flags, decoded from the upcoming state so they line up
  // with the state register.
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_SHIFT);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Dout   = busy_r & chain_q_s[WIDTH-1];
  assign RxData = rx_r;

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for serial_xfer_ctrl (WIDTH=8, LEN_W=4).
// Table-driven transfers plus hand-written sequences for held Start,
// mid-transfer reset and idle behaviour. Outputs are sampled on the falling
// edge; inputs change there too.
// ----------------------------------------------------------------------------
module tb_serial_xfer_ctrl;
  import serial_xfer_ctrl_pkg::*;

  logic       Clkin = 1'b0;
  logic       Resetn;
  logic       Start;
  logic [3:0] Len;
  logic [7:0] DataIn;
  logic       Din;
  logic       Dout;
  logic       Busy;
  logic       Done;
  logic [7:0] RxData;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [3:0] len;
    logic [7:0] data;
    logic [7:0] din;      // bit i is the i-th Din bit sent
    int         n;        // hand-computed effective length
    logic [7:0] rx;       // hand-computed expected RxData
    bit         scramble; // change DataIn/Len during the transfer
  } vec_t;

  vec_t vecs[8];

  serial_xfer_ctrl #(.WIDTH(8), .LEN_W(4)) dut (
    .Clkin  (Clkin),
    .Resetn (Resetn),
    .Start  (Start),
    .Len    (Len),
    .DataIn (DataIn),
    .Din    (Din),
    .Dout   (Dout),
    .Busy   (Busy),
    .Done   (Done),
    .RxData (RxData)
  );

  always #5 Clkin = ~Clkin;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One transfer: request, N shift cycles, Done cycle, following idle cycle.
  task automatic run_xfer(input vec_t v);
    int unsigned nm;
    logic [7:0]  data;
    data = v.data;
    nm   = eff_len(32'(v.len), 32'd8);
    @(negedge Clkin);
    Start  = 1'b1;
    Len    = v.len;
    DataIn = v.data;
    @(negedge Clkin);               // cycle k+1
    Start = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      check("busy", 32'(Busy), 32'd1);
      check("done_in_shift", 32'(Done), 32'd0);
      check("dout", 32'(Dout), 32'(data[nm-1-i]));
      Din = v.din[i];
      if (v.scramble) begin
        DataIn = 8'($urandom);
        Len    = 4'($urandom_range(0, 15));
        Start  = 1'b1;              // ignored outside IDLE
      end
      @(negedge Clkin);
    end
    Start = 1'b0;
    check("done", 32'(Done), 32'd1);
    check("busy_in_done", 32'(Busy), 32'd0);
    check("dout_in_done", 32'(Dout), 32'd0);
    check("rxdata", 32'(RxData), 32'(v.rx));
    @(negedge Clkin);
    check("done_width", 32'(Done), 32'd0);
    check("busy_after", 32'(Busy), 32'd0);
    check("rxdata_hold", 32'(RxData), 32'(v.rx));
  endtask

  initial begin
    logic [7:0] last_rx;
    int         busy_pat [11];
    int         done_pat [11];

    vecs[0] = '{4'd8,  8'hA5, 8'h59, 8, 8'h9A, 1'b0};
    vecs[1] = '{4'd3,  8'hFD, 8'h03, 3, 8'h06, 1'b0};
    vecs[2] = '{4'd0,  8'hA5, 8'h59, 8, 8'h9A, 1'b0};
    vecs[3] = '{4'd9,  8'h3C, 8'hE6, 8, 8'h67, 1'b0};
    vecs[4] = '{4'd1,  8'hFE, 8'h01, 1, 8'h01, 1'b0};
    vecs[5] = '{4'd4,  8'h5A, 8'h0F, 4, 8'h0F, 1'b0};
    vecs[6] = '{4'd5,  8'h93, 8'h1A, 5, 8'h0B, 1'b1};
    vecs[7] = '{4'd15, 8'hC3, 8'h80, 8, 8'h01, 1'b0};

    Resetn = 1'b0;
    Start  = 1'b0;
    Len    = 4'd0;
    DataIn = 8'h00;
    Din    = 1'b0;
    repeat (2) @(negedge Clkin);
    check("rst_dout", 32'(Dout), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_rx", 32'(RxData), 32'd0);
    Resetn = 1'b1;
    @(negedge Clkin);

    for (int v = 0; v < 8; v++) begin
      run_xfer(vecs[v]);
    end
    last_rx = vecs[7].rx;

    // Idle: random Din must not disturb anything.
    for (int c = 0; c < 10; c++) begin
      Din = 1'($urandom);
      @(negedge Clkin);
      check("idle_dout", 32'(Dout), 32'd0);
      check("idle_busy", 32'(Busy), 32'd0);
      check("idle_done", 32'(Done), 32'd0);
      check("idle_rx", 32'(RxData), 32'(last_rx));
    end

    // Start held high with Len=2: accepted at k, k+4, k+8.
    busy_pat = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    done_pat = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    Start  = 1'b1;
    Len    = 4'd2;
    DataIn = 8'h02;
    Din    = 1'b1;
    @(negedge Clkin);               // edge k has accepted
    for (int c = 0; c < 11; c++) begin
      check("held_busy", 32'(Busy), 32'(busy_pat[c]));
      check("held_done", 32'(Done), 32'(done_pat[c]));
      @(negedge Clkin);
    end
    Start = 1'b0;
    check("held_rx", 32'(RxData), 32'h3);
    repeat (3) @(negedge Clkin);

    // Mid-transfer reset during cycle k+4 of a Len=8 transfer.
    Start  = 1'b1;
    Len    = 4'd8;
    DataIn = 8'hFF;
    Din    = 1'b1;
    @(negedge Clkin);               // cycle k+1
    Start = 1'b0;
    repeat (3) @(negedge Clkin);    // cycle k+4
    check("pre_rst_busy", 32'(Busy), 32'd1);
    #2 Resetn = 1'b0;
    #1;
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_dout", 32'(Dout), 32'd0);
    check("arst_done", 32'(Done), 32'd0);
    check("arst_rx", 32'(RxData), 32'd0);
    @(negedge Clkin);
    Resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clkin);
      check("post_rst_done", 32'(Done), 32'd0);
      check("post_rst_busy", 32'(Busy), 32'd0);
    end
    run_xfer(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_xfer_ctrl.md
# serial_xfer_ctrl

Controller that sequences a WIDTH-bit chain of D flip-flops as a full-duplex serial shifter. On a Start request it loads a parallel word, shifts it out MSB-first one bit per clock on Dout while capturing Din into the same chain, then presents the captured word with a one-cycle Done pulse. It sits between a parallel host, such as a lab FSM or switches, and a serial link or the lab flip-flop chain under test.

## Interface
- WIDTH, 8, width of the shift chain and of the parallel words (2..16)
- LEN_W, 4, width of Len; must satisfy 2^LEN_W > WIDTH

- Clkin  input  1  clock; all state changes on the rising edge
- Resetn  input  1  asynchronous, active-low reset
- Start  input  1  transfer request; sampled only in IDLE
- Len  input  LEN_W  bit count N for the transfer; 0 or >WIDTH means N=WIDTH
- DataIn  input  WIDTH  parallel word to send; bits [N-1:0] are sent
- Din  input  1  serial receive bit
- Dout  output  1  serial transmit bit
- Busy  output  1  high while shifting
- Done  output  1  one-cycle completion pulse
- RxData  output  WIDTH  captured word, valid from the Done cycle until the next Done

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (Resetn=0, asynchronous): state=IDLE; shift chain, bit counter and latched N are 0; Dout=0, Busy=0, Done=0, RxData=0.
- IDLE: Dout=0, Busy=0.
  - When Start=1 at an edge: latch N; load chain <= DataIn << (WIDTH-N), so DataIn[N-1] sits at the chain MSB; counter <= N; go to SHIFT.
- SHIFT: Busy=1; Dout = chain[WIDTH-1] (combinational from the register).
  - Each edge: chain <= {chain[WIDTH-2:0], Din}; counter <= counter-1.
  - On the edge where counter==1: RxData <= {chain[WIDTH-2:0], Din} masked to bits [N-1:0], upper bits 0. Go to DONE.
- DONE: Done=1, Busy=0, Dout=0; unconditionally go to IDLE at the next edge.
- Start is ignored in SHIFT and DONE; no queuing.
- Len and DataIn are sampled only on the Start edge. Later changes have no effect on the transfer in progress.
- Received bit order: the first Din bit lands in RxData[N-1] and the last in RxData[0].
- Reset asserted mid-transfer aborts immediately: no Done pulse, and RxData clears to 0.

## Timing
- Start accepted at edge k:
  - Busy is high in cycles k+1 .. k+N.
  - Dout carries DataIn[N-1-i] during cycle k+1+i, for i = 0..N-1.
  - Din is sampled at the end of cycle k+1+i, i.e. at edge k+2+i.
  - Done and valid RxData appear in cycle k+N+1.
- Earliest next accepted Start is at edge k+N+2, so back-to-back transfers have a 2-cycle gap (DONE plus one IDLE edge).
- Busy and Done are never high together. Done is exactly one cycle wide.
- N=1 is legal: one SHIFT cycle, then DONE.

## Structure
- A shared header holds:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 recovers to IDLE
  - the effective-length rule (0 or >WIDTH maps to WIDTH) as a macro/function, reused by the testbench model
- Sub-module shift_chain: a WIDTH-bit register with async active-low clear and load/shift enables, built as a chain of D flip-flops.
- serial_xfer_ctrl contains the FSM, bit counter, N latch, mask logic and RxData register.

## Test plan
- Full-width transfer: WIDTH=8, Len=8, DataIn=8'hA5, Din stream 1,0,0,1,1,0,1,0 -> Dout 1,0,1,0,0,1,0,1 in cycles k+1..k+8; Done at k+9; RxData=8'h9A; Busy high for exactly 8 cycles.
- Short transfer: Len=3, DataIn=8'hFD, Din stream 1,1,0 -> Dout 1,0,1; Done at k+4; RxData=8'h06.
- Length clamping: Len=0, and separately Len=9 -> both behave as N=8 (8 Busy cycles, Done at k+9).
- Request handling: Start held high continuously with Len=2 -> accepted at edges k, k+4, k+8. Start pulses during SHIFT and DONE are ignored. DataIn and Len changed mid-transfer -> no effect on Dout or RxData.
- Mid-transfer reset: Resetn low asynchronously during cycle k+4 of a Len=8 transfer -> immediately IDLE, all outputs 0, no Done. After release, a new Start operates normally.
- Idle behaviour: with Start=0, Din toggling randomly -> Dout=0, Busy=0, Done=0, and RxData holds its last value indefinitely.
